// File: rtl/perf_counter_bank_pkg.sv
// perf_pkg: shared state type and sizing helpers for the counter bank.
// Build option PERF_SATURATE_EN selects saturating counters with ovf flags.
package perf_pkg;

  typedef enum logic [1:0] {
    COUNT,
    DUMP,
    DONE
  } perfState_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int dumpLen(input int numEvt);
    return numEvt + 1;
  endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// Dump port of the counter bank: valid/ready stream of (idx, data) words.
// master: bank drives valid/idx/data/done; slave: consumer drives ready.
interface perf_counter_bank_if #(
  parameter int IDX_W = 3,
  parameter int CNT_W = 32
);
  logic             dump_valid;
  logic             dump_ready;
  logic [IDX_W-1:0] dump_idx;
  logic [CNT_W-1:0] dump_data;
  logic             dump_done;

  modport master (
    output dump_valid, dump_idx, dump_data, dump_done,
    input  dump_ready
  );

  modport slave (
    input  dump_valid, dump_idx, dump_data, dump_done,
    output dump_ready
  );
endinterface

// File: rtl/perf_counter_bank_counter.sv
// perf_counter: one CNT_W event counter. Ports: clk, rst, inc, clr, freeze, val,
// plus sticky ovf when PERF_SATURATE_EN is defined (counter then saturates).
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             freeze,
  output logic [CNT_W-1:0] val
`ifdef PERF_SATURATE_EN
  ,
  output logic             ovf
`endif
);

  logic bump;
  assign bump = inc && !freeze;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val <= '0;
    end else if (clr) begin
      val <= '0;
    end else if (bump) begin
`ifdef PERF_SATURATE_EN
      if (val != '1) val <= val + CNT_W'(1);
`else
      val <= val + CNT_W'(1);
`endif
    end
  end

`ifdef PERF_SATURATE_EN
  // Sticky: set by any increment attempted while already at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (clr) begin
      ovf <= 1'b0;
    end else if (bump && (val == '1)) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: cycle + NUM_EVT event counters; halt freezes and dumps them.
// Ports: clk, rst, evt, halt, clr, frozen, cycle_cnt, dump (if); ovf with PERF_SATURATE_EN.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               halt,
  input  logic               clr,
  output logic               frozen,
  output logic [CNT_W-1:0]   cycle_cnt,
`ifdef PERF_SATURATE_EN
  output logic [NUM_EVT:0]   ovf,
`endif
  perf_counter_bank_if.master dump
);

  localparam int IDX_W    = clog2(NUM_EVT + 1);
  localparam int DUMP_LEN = dumpLen(NUM_EVT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DUMP_LEN - 1);

  perfState_t       state, stateNext;
  logic [IDX_W-1:0] ptr, ptrNext;
  logic [CNT_W-1:0] cnt [NUM_EVT+1];
  logic [NUM_EVT:0] inc;
  logic             freeze;
  logic [CNT_W-1:0] rdData;

  // Slot 0 is the free-running cycle counter.
  assign inc    = {evt, 1'b1};
  assign freeze = (state != COUNT);

  for (genvar g = 0; g <= NUM_EVT; g++) begin : gCnt
    perf_counter #(.CNT_W(CNT_W)) uCnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (inc[g]),
      .clr    (clr),
      .freeze (freeze),
      .val    (cnt[g])
`ifdef PERF_SATURATE_EN
      ,
      .ovf    (ovf[g])
`endif
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COUNT;
      ptr   <= '0;
    end else begin
      state <= stateNext;
      ptr   <= ptrNext;
    end
  end

  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    if (clr) begin
      stateNext = COUNT;
      ptrNext   = '0;
    end else begin
      unique case (state)
        COUNT: if (halt) stateNext = DUMP;
        DUMP: begin
          if (dump.dump_ready) begin
            if (ptr == LAST_IDX) stateNext = DONE;
            else ptrNext = ptr + IDX_W'(1);
          end
        end
        DONE: stateNext = DONE;
        default: stateNext = COUNT;
      endcase
    end
  end

  always_comb begin
    rdData = '0;
    for (int i = 0; i <= NUM_EVT; i++)
      if (ptr == IDX_W'(i)) rdData = cnt[i];
  end

  assign frozen          = freeze;
  assign cycle_cnt       = cnt[0];
  assign dump.dump_valid = (state == DUMP);
  assign dump.dump_done  = (state == DONE);
  assign dump.dump_idx   = ptr;
  assign dump.dump_data  = (state == DUMP) ? rdData : '0;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank (NUM_EVT=4, CNT_W=8).
// Honours PERF_SATURATE_EN to match the saturating build.
module tb_perf_counter_bank;
  import perf_pkg::*;

  localparam int NUM_EVT = 4;
  localparam int CNT_W   = 8;
  localparam int IDX_W   = clog2(NUM_EVT + 1);
  localparam int WORDS   = NUM_EVT + 1;
  localparam int MAXV    = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NUM_EVT-1:0] evt = '0;
  logic               halt = 1'b0;
  logic               clr = 1'b0;
  logic               frozen;
  logic [CNT_W-1:0]   cycle_cnt;
`ifdef PERF_SATURATE_EN
  logic [NUM_EVT:0]   ovf;
`endif

  perf_counter_bank_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dif ();

  perf_counter_bank #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .evt       (evt),
    .halt      (halt),
    .clr       (clr),
    .frozen    (frozen),
    .cycle_cnt (cycle_cnt),
`ifdef PERF_SATURATE_EN
    .ovf       (ovf),
`endif
    .dump      (dif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int data;
  } word_t;

  word_t expQ[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: plain integer counts and dump progress.
  int    mCnt[WORDS];
  bit    mOvf[WORDS];
  bit    mFrozen;
  bit    mDone;
  int    mSent;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < WORDS; i++) begin
      mCnt[i] = 0;
      mOvf[i] = 1'b0;
    end
    mFrozen = 1'b0;
    mDone   = 1'b0;
    mSent   = 0;
    expQ.delete();
  endtask

  task automatic modelBump(input int k);
`ifdef PERF_SATURATE_EN
    if (mCnt[k] == MAXV) mOvf[k] = 1'b1;
    else mCnt[k] = mCnt[k] + 1;
`else
    mCnt[k] = (mCnt[k] + 1) % (MAXV + 1);
`endif
  endtask

  // One clock cycle: drive inputs, let the edge happen, advance the model.
  task automatic step(input logic [NUM_EVT-1:0] e, input bit h,
                      input bit c, input bit r);
    evt = e;
    halt = h;
    clr = c;
    dif.dump_ready = r;
    @(posedge clk);
    if (c) begin
      modelClear();
    end else if (!mFrozen) begin
      modelBump(0);
      for (int i = 0; i < NUM_EVT; i++)
        if (e[i]) modelBump(i + 1);
      if (h) begin
        mFrozen = 1'b1;
        for (int i = 0; i < WORDS; i++)
          expQ.push_back('{i, mCnt[i]});
      end
    end else if (!mDone && r) begin
      mSent++;
      if (mSent == WORDS) mDone = 1'b1;
    end
    #1;
  endtask

  task automatic checkState(input string tag);
    check({tag, ".frozen"}, longint'(frozen), longint'(mFrozen));
    check({tag, ".valid"}, longint'(dif.dump_valid),
          longint'(mFrozen && !mDone));
    check({tag, ".done"}, longint'(dif.dump_done), longint'(mDone));
    check({tag, ".cycle"}, longint'(cycle_cnt), longint'(mCnt[0]));
    if (mFrozen && !mDone) begin
      check({tag, ".idx"}, longint'(dif.dump_idx), longint'(mSent));
      check({tag, ".data"}, longint'(dif.dump_data), longint'(mCnt[mSent]));
    end
`ifdef PERF_SATURATE_EN
    begin
      logic [NUM_EVT:0] ev;
      for (int i = 0; i < WORDS; i++) ev[i] = mOvf[i];
      check({tag, ".ovf"}, longint'(ovf), longint'(ev));
    end
`endif
  endtask

  // Monitor: every accepted dump word is popped and compared.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !clr && dif.dump_valid && dif.dump_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected: idx %0d data %0d, none expected",
                   dif.dump_idx, dif.dump_data);
        end else begin
          word_t w;
          w = expQ.pop_front();
          check("mon_idx", longint'(dif.dump_idx), longint'(w.idx));
          check("mon_data", longint'(dif.dump_data), longint'(w.data));
        end
      end
    end
  end

  initial begin
    modelClear();
    dif.dump_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.frozen", longint'(frozen), 0);
    check("rst.valid", longint'(dif.dump_valid), 0);
    check("rst.done", longint'(dif.dump_done), 0);
    check("rst.idx", longint'(dif.dump_idx), 0);
    check("rst.data", longint'(dif.dump_data), 0);
    check("rst.cycle", longint'(cycle_cnt), 0);
    rst = 1'b0;

    // Basic count with halt on the 10th cycle.
    for (int i = 0; i < 10; i++) step(4'b0001, i == 9, 1'b0, 1'b1);
    checkState("s1_halt");
    check("s1_word0", longint'(dif.dump_data), 10);
    step('0, 1'b0, 1'b0, 1'b1);
    check("s1_word1", longint'(dif.dump_data), 10);
    repeat (WORDS - 1) begin
      step('0, 1'b0, 1'b0, 1'b1);
      checkState("s1_dump");
    end
    check("s1_done", longint'(dif.dump_done), 1);
    check("s1_q", longint'(expQ.size()), 0);

    // Backpressure at idx 2.
    step('0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(4'b0001, i == 9, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b1);
    repeat (3) begin
      step('0, 1'b0, 1'b0, 1'b0);
      check("s2_idx", longint'(dif.dump_idx), 2);
      check("s2_data", longint'(dif.dump_data), 0);
      checkState("s2_hold");
    end
    repeat (3) step('0, 1'b0, 1'b0, 1'b1);
    checkState("s2_end");
    check("s2_done", longint'(dif.dump_done), 1);

    // Wrap or saturate on evt[2].
    step('0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) step(4'b0100, i == 299, 1'b0, 1'b0);
    repeat (3) step('0, 1'b0, 1'b0, 1'b1);
    check("s3_idx", longint'(dif.dump_idx), 3);
`ifdef PERF_SATURATE_EN
    check("s3_data", longint'(dif.dump_data), 255);
    check("s3_ovf3", longint'(ovf[3]), 1);
`else
    check("s3_data", longint'(dif.dump_data), 44);
`endif
    checkState("s3");
    repeat (2) step('0, 1'b0, 1'b0, 1'b1);
    checkState("s3_end");

    // clr mid-dump with ready high.
    step('0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++)
      step(NUM_EVT'($urandom), i == 5, 1'b0, 1'b1);
    repeat (2) step('0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1, 1'b1);
    check("s4_valid", longint'(dif.dump_valid), 0);
    check("s4_frozen", longint'(frozen), 0);
    check("s4_cycle0", longint'(cycle_cnt), 0);
    checkState("s4_clr");
    step('0, 1'b0, 1'b0, 1'b0);
    check("s4_cycle1", longint'(cycle_cnt), 1);

    // halt and clr together after 7 cycles.
    step('0, 1'b0, 1'b1, 1'b0);
    repeat (6) step(4'b1111, 1'b0, 1'b0, 1'b0);
    step(4'b1111, 1'b1, 1'b1, 1'b1);
    check("s5_frozen", longint'(frozen), 0);
    check("s5_cycle", longint'(cycle_cnt), 0);
    check("s5_valid", longint'(dif.dump_valid), 0);
    step('0, 1'b0, 1'b0, 1'b1);
    checkState("s5_after");

    // halt in DONE is ignored.
    step('0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0010, i == 2, 1'b0, 1'b1);
    repeat (WORDS) step('0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b1);
    check("s6_done", longint'(dif.dump_done), 1);
    check("s6_frozen", longint'(frozen), 1);
    checkState("s6_done_halt");

    // Asynchronous reset between edges, mid-dump.
    step('0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b1001, i == 3, 1'b0, 1'b1);
    repeat (2) step('0, 1'b0, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("s6_rst.valid", longint'(dif.dump_valid), 0);
    check("s6_rst.frozen", longint'(frozen), 0);
    check("s6_rst.idx", longint'(dif.dump_idx), 0);
    check("s6_rst.data", longint'(dif.dump_data), 0);
    check("s6_rst.cycle", longint'(cycle_cnt), 0);
    modelClear();
    rst = 1'b0;
    step('0, 1'b0, 1'b0, 1'b0);
    checkState("s6_post_rst");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(NUM_EVT'($urandom),
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 63) == 0,
           $urandom_range(0, 3) != 0);
      checkState("rnd");
    end
    repeat (WORDS + 1) step('0, 1'b0, 1'b0, 1'b1);
    checkState("end");
    check("end_q", longint'(expQ.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Synthesizable, parametrised event-counter bank for the processor hierarchy.
- Counts cycles plus NUM_EVT per-cycle event strobes: instruction retire, I/D cache request and hit, and others.
- Freezes on halt, then streams every counter out through a valid/ready dump port.
- Replaces bench-only counting with hardware usable in simulation and on FPGA.

Parameters:
- NUM_EVT, 4, number of event strobe inputs (1..15).
- CNT_W, 32, width of every counter (8..64).
- IDX_W, derived, clog2(NUM_EVT+1); index width of the dump port.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- evt  in  NUM_EVT  event strobes; bit i high means event i occurred this cycle.
- halt  in  1  processor halt strobe, from the memory/writeback halt flag.
- clr  in  1  synchronous clear of all counters; returns the block to COUNT.
- frozen  out  1  high once halt is accepted, until clr or rst.
- cycle_cnt  out  CNT_W  live value of counter 0.
- dump_valid  out  1  dump word valid.
- dump_ready  in  1  consumer accepts the dump word.
- dump_idx  out  IDX_W  index of the current counter: 0 = cycles, i+1 = evt[i].
- dump_data  out  CNT_W  value of the counter selected by dump_idx.
- dump_done  out  1  all NUM_EVT+1 words have been transferred.

Behaviour:
- Reset (asynchronous, rst=1):
  - All counters and the dump pointer go to 0; state goes to COUNT.
  - frozen, dump_valid, dump_done and dump_idx are 0; dump_data is 0.
- States are COUNT, DUMP and DONE.
- COUNT:
  - Counter 0 increments every cycle.
  - Counter i+1 increments in each cycle where evt[i]=1.
  - Counting is one cycle late: the value updates on the edge after the strobe.
- Halt acceptance:
  - halt=1 in COUNT (with clr=0): that cycle's cycle tick and events are still counted.
  - Next state is DUMP; frozen=1 from the next cycle on.
  - No counter changes after this point.
- DUMP:
  - dump_valid=1; dump_idx=ptr; dump_data=counter[ptr].
  - Handshake occurs when dump_valid and dump_ready are both high; ptr then increments.
  - With dump_ready=0, dump_idx and dump_data hold stable.
  - A handshake at ptr=NUM_EVT moves the block to DONE.
  - Minimum dump length is NUM_EVT+1 cycles.
- DONE:
  - dump_valid=0, dump_done=1, frozen=1.
  - The state holds until clr or rst.
- halt while in DUMP or DONE is ignored.
- clr:
  - Takes effect in any state and has priority over halt and over a dump handshake in the same cycle.
  - Next cycle: all counters 0, ptr 0, state COUNT, frozen/dump_valid/dump_done all 0.
  - The clr cycle's events and cycle tick are not counted.
- Arithmetic: unsigned modulo 2^CNT_W (wraps from all-ones to 0) unless the optional feature is enabled.
- rst asserted mid-dump aborts immediately (asynchronous); no partial state is retained.

Optional Feature:
- Macro PERF_SATURATE_EN.
- Defined:
  - Each counter sticks at all-ones instead of wrapping.
  - Adds output ovf [NUM_EVT:0]: per-counter sticky bit, set on an increment attempted at all-ones.
  - ovf is cleared by clr or rst.
  - During DUMP, ovf[ptr] is visible on the ovf vector.
- Undefined: modulo wrap; no ovf port.

Decomposition:
- Package perf_pkg:
  - State enum {COUNT, DUMP, DONE}.
  - Function clog2 used for IDX_W.
  - Constant DUMP_LEN = NUM_EVT+1, as a function of the parameter.
- Sub-module perf_counter: one CNT_W counter with inputs inc, clr, freeze and output val.
  - Contains the wrap/saturate logic and the ovf bit under PERF_SATURATE_EN.
  - Instantiated NUM_EVT+1 times via generate.

Test Plan:
1. Basic count (NUM_EVT=4, CNT_W=8): release rst, evt=4'b0001 for 10 cycles, halt on the 10th, dump_ready=1 → dump words idx0=10, idx1=10, idx2..4=0; dump_done high after 5 handshakes.
2. Backpressure: start as in scenario 1, then hold dump_ready=0 for 3 cycles at idx 2 → dump_idx=2 and dump_data=0 held for 3 cycles; no ptr advance; sequence completes after ready returns.
3. Wrap vs saturate: evt[2]=1 for 300 cycles, then halt → idx3=44 without the macro; idx3=255 and ovf[3]=1 with PERF_SATURATE_EN.
4. clr mid-dump: clr at idx 2 with dump_ready=1 → next cycle dump_valid=0, frozen=0, all counters 0; one further COUNT cycle gives cycle_cnt=1.
5. halt and clr in the same cycle after 7 cycles → counters cleared, no dump, state COUNT, frozen=0.
6. Ignored and async events: halt pulsed in DONE → no change, dump_done stays 1; rst asserted mid-dump between clock edges → outputs 0 immediately, before the next clk edge.
